// File: rtl/branch_resolve_if.sv
// Bundles the fetch/pipeline/resolve inputs and the redirect/update outputs of branch_resolve.
`default_nettype none

interface branch_resolve_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] pc_if;
  logic                  predict_taken_if;
  logic [ADDR_WIDTH-1:0] predict_target_pc_if;
  logic                  is_loop_if;
  logic                  if_adv;
  logic                  dec_adv;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic [ADDR_WIDTH-1:0] resolve_target_pc;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  flush;
  logic                  branch_ex;
  logic                  branch_taken_ex;
  logic [ADDR_WIDTH-1:0] branch_pc_ex;
  logic [ADDR_WIDTH-1:0] branch_target_pc;
  logic                  is_loop_ex;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  mispredict_cnt;

  modport master (
    output if_valid, pc_if, predict_taken_if, predict_target_pc_if, is_loop_if,
           if_adv, dec_adv, resolve_valid, resolve_taken, resolve_target_pc, ex_pc,
    input  redirect_valid, redirect_pc, flush, branch_ex, branch_taken_ex,
           branch_pc_ex, branch_target_pc, is_loop_ex, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_valid, pc_if, predict_taken_if, predict_target_pc_if, is_loop_if,
           if_adv, dec_adv, resolve_valid, resolve_taken, resolve_target_pc, ex_pc,
    output redirect_valid, redirect_pc, flush, branch_ex, branch_taken_ex,
           branch_pc_ex, branch_target_pc, is_loop_ex, branch_cnt, mispredict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve.sv
// Carries fetch-time branch predictions to EX, detects mispredicts, issues redirect/flush,
// drives the predictor update strobe and keeps saturating branch/mispredict counters.
`default_nettype none

module branch_resolve #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  branch_resolve_if.slave   bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic                  loop;
  } pred_t;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t                state_q, state_d;
  logic [2:0]            fcnt_q, fcnt_d;
  pred_t                 dec_q, dec_d, ex_q, ex_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  flush_q, flush_d;
  logic                  branch_ex_q, branch_ex_d;
  logic                  branch_taken_q, branch_taken_d;
  logic [ADDR_WIDTH-1:0] branch_pc_q, branch_pc_d;
  logic [ADDR_WIDTH-1:0] branch_target_q, branch_target_d;
  logic                  is_loop_q, is_loop_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

  logic                  match;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] correct_pc;

  // A prediction only counts if the EX slot really carries the resolving instruction.
  assign match       = ex_q.valid && (ex_q.pc == bus.ex_pc);
  assign pred_taken  = match && ex_q.taken;
  assign pred_target = match ? ex_q.target : '0;
  assign mispredict  = (pred_taken != bus.resolve_taken) ||
                       (pred_taken && bus.resolve_taken && (pred_target != bus.resolve_target_pc));
  assign correct_pc  = bus.resolve_taken ? bus.resolve_target_pc
                                         : bus.ex_pc + ADDR_WIDTH'(4);

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    dec_d            = dec_q;
    ex_d             = ex_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    branch_ex_d      = 1'b0;
    branch_taken_d   = branch_taken_q;
    branch_pc_d      = branch_pc_q;
    branch_target_d  = branch_target_q;
    is_loop_d        = is_loop_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (flush_q) begin
      dec_d.valid = 1'b0;
      ex_d.valid  = 1'b0;
    end else begin
      if (bus.dec_adv) ex_d = dec_q;
      if (bus.if_adv) begin
        dec_d = '{valid: bus.if_valid, pc: bus.pc_if, taken: bus.predict_taken_if,
                  target: bus.predict_target_pc_if, loop: bus.is_loop_if};
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.resolve_valid) begin
          branch_ex_d     = 1'b1;
          branch_taken_d  = bus.resolve_taken;
          branch_pc_d     = bus.ex_pc;
          branch_target_d = bus.resolve_target_pc;
          is_loop_d       = match && ex_q.loop;
          if (~&branch_cnt_q) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
          if (mispredict) begin
            if (~&mispredict_cnt_q) mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
            redirect_valid_d = 1'b1;
            redirect_pc_d    = correct_pc;
            flush_d          = 1'b1;
            fcnt_d           = FCNT_INIT;
            state_d          = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      dec_q            <= '0;
      ex_q             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      branch_ex_q      <= 1'b0;
      branch_taken_q   <= 1'b0;
      branch_pc_q      <= '0;
      branch_target_q  <= '0;
      is_loop_q        <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      dec_q            <= dec_d;
      ex_q             <= ex_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_ex_q      <= branch_ex_d;
      branch_taken_q   <= branch_taken_d;
      branch_pc_q      <= branch_pc_d;
      branch_target_q  <= branch_target_d;
      is_loop_q        <= is_loop_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.flush            = flush_q;
  assign bus.branch_ex        = branch_ex_q;
  assign bus.branch_taken_ex  = branch_taken_q;
  assign bus.branch_pc_ex     = branch_pc_q;
  assign bus.branch_target_pc = branch_target_q;
  assign bus.is_loop_ex       = is_loop_q;
  assign bus.branch_cnt       = branch_cnt_q;
  assign bus.mispredict_cnt   = mispredict_cnt_q;

endmodule

`default_nettype wire

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Write-side counterpart to the fetch-stage branch predictor.
- Carries each fetch-time prediction (taken, target, loop flag) down the IF->DEC->EX pipeline.
- At EX, compares the prediction with the resolved outcome and issues the redirect/flush on a mispredict.
- Drives the predictor update strobe (branch_ex, branch_taken_ex, branch_pc_ex, branch_target_pc, is_loop_ex) and keeps saturating branch/mispredict counters.

Parameters:
- ADDR_WIDTH, 32, PC width.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (1..7).
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- cpu_clk  input  1  core clock
- cpu_rstn  input  1  reset, synchronous, active-low
- if_valid  input  1  IF holds a valid fetched instruction
- pc_if  input  ADDR_WIDTH  PC of the IF instruction
- predict_taken_if  input  1  predictor taken output for pc_if
- predict_target_pc_if  input  ADDR_WIDTH  predictor target for pc_if
- is_loop_if  input  1  predictor loop flag for pc_if
- if_adv  input  1  IF->DEC transfer this cycle
- dec_adv  input  1  DEC->EX transfer this cycle
- resolve_valid  input  1  conditional branch resolved in EX this cycle
- resolve_taken  input  1  actual direction
- resolve_target_pc  input  ADDR_WIDTH  actual taken target
- ex_pc  input  ADDR_WIDTH  PC of the EX instruction
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  ADDR_WIDTH  redirect address
- flush  output  1  squash IF/DEC
- branch_ex  output  1  predictor update strobe
- branch_taken_ex  output  1  update direction
- branch_pc_ex  output  ADDR_WIDTH  update index/tag PC
- branch_target_pc  output  ADDR_WIDTH  update target
- is_loop_ex  output  1  update loop flag
- branch_cnt  output  CNT_WIDTH  resolved branches
- mispredict_cnt  output  CNT_WIDTH  mispredicts

Behaviour:
- Reset (cpu_rstn low at a clock edge): all outputs 0, counters 0, pipeline valid bits 0, FSM in IDLE. Applies mid-flush as well.
- Prediction pipe, DEC stage: stage holds {valid, pc, taken, target, loop}. On if_adv it loads the IF fields, with valid = if_valid; otherwise it holds.
- Prediction pipe, EX stage: on dec_adv it loads the DEC stage; otherwise it holds.
- Flush or reset clears both valid bits. Flush beats if_adv/dec_adv in the same cycle.
- Prediction match: EX entry is used only if valid and its pc == ex_pc. Otherwise the prediction is taken as not-taken with target 0.
- Mispredict is evaluated combinationally when resolve_valid is high in IDLE:
  - pred_taken != resolve_taken, or
  - pred_taken and resolve_taken and pred_target != resolve_target_pc.
- Correct-path PC: resolve_taken ? resolve_target_pc : ex_pc + 4, modulo 2^ADDR_WIDTH.
- Update strobe, registered with 1-cycle latency after resolve_valid (IDLE only), issued whether or not the branch mispredicted:
  - branch_ex = 1, branch_taken_ex = resolve_taken, branch_pc_ex = ex_pc, branch_target_pc = resolve_target_pc, is_loop_ex = EX loop flag when matched, else 0.
  - branch_ex is deasserted the next cycle unless a new resolve occurs. The data outputs hold their last value.
- FSM state IDLE:
  - On resolve_valid with mispredict: next cycle redirect_valid = 1, redirect_pc = correct-path PC, flush = 1; go to FLUSH with fcnt = FLUSH_CYCLES - 1.
- FSM state FLUSH:
  - flush = 1, redirect_valid = 0.
  - resolve_valid is ignored: no update, no count.
  - fcnt decrements each cycle; at fcnt == 0 go to IDLE, and flush drops the following cycle.
  - With FLUSH_CYCLES = 1, flush is high for exactly one cycle, coincident with redirect_valid.
- Counters, registered alongside the update strobe:
  - branch_cnt increments on each accepted resolve.
  - mispredict_cnt increments on each accepted mispredict.
  - Both saturate at all-ones and never wrap.
- redirect_pc holds its value after the pulse.

Test Plan:
- Reset then 3 idle cycles -> all outputs 0; counters 0.
- Predict taken target 0x100 at pc 0x40; resolve taken 0x100 at ex_pc 0x40 -> next cycle branch_ex = 1, branch_pc_ex = 0x40, branch_target_pc = 0x100; redirect_valid 0; branch_cnt = 1, mispredict_cnt = 0.
- Predict not-taken at pc 0x80; resolve taken 0x200 -> redirect_valid pulse with redirect_pc 0x200; flush high 2 cycles; mispredict_cnt = 1.
- Predict taken 0x300 at pc 0xFFFFFFFC; resolve not-taken -> redirect_pc 0x00000000 (wrap).
- During FLUSH, assert resolve_valid together with dec_adv -> no branch_ex, counters unchanged, EX valid cleared. Separately, set pc mismatch (pipe pc 0x40, ex_pc 0x44) with resolve taken -> mispredict.
- Preload branch_cnt to saturation via 2^CNT_WIDTH resolves, using CNT_WIDTH = 4 -> holds at 15. Separately, assert cpu_rstn low mid-FLUSH -> flush 0 and FSM in IDLE next cycle.
